rv32im_icache_assoc: RTL and testbench

//  Set-associative, parametrised successor to the direct-line-tagged instruction cache in the rv32im core.
//  - Sits between the fetch stage and the shared wishbone arbiter.
//  - Refills whole lines through the arbiter; round-robin replacement per set.
//  - Bus-error abort, whole-cache flush and a misaligned-fetch flag.

---
 rtl/rv32im_icache_assoc.sv | 279 +++++++++++++++++++++++++++
 tb/tb_rv32im_icache_assoc.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_icache_assoc.sv
// rv32im_icache_assoc
//   Set-associative instruction cache between the fetch stage and the shared
//   wishbone arbiter. It refills whole lines through the arbiter and picks a
//   round-robin victim per set. It also handles bus-error abort, whole-cache
//   flush and a registered misaligned-fetch flag.
//   Optional build macro ICACHE_PERF_EN adds hit_count_o / miss_count_o.
module rv32im_icache_assoc #(
    parameter int XLEN             = 32,
    parameter int ILEN             = 32,
    parameter int WAY_LEN          = 1,
    parameter int SET_LEN          = 2,
    parameter int LINE_LEN         = 4,
    parameter int UNUSED_ADDR_BITS = 8
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              req_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic              flush_i,
    output logic [ILEN-1:0]   instr_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              misaligned_o,
    output logic              fault_o,
    output logic              ctrl_req_o,
    input  logic              ctrl_grant_i,
    input  logic [XLEN-1:0]   master_dat_i,
    input  logic              ack_i,
    input  logic              err_i,
    output logic [XLEN-3:0]   adr_o,
    output logic              cyc_o,
    output logic              stb_o,
    output logic [3:0]        sel_o
`ifdef ICACHE_PERF_EN
    ,
    output logic [XLEN-1:0]   hit_count_o,
    output logic [XLEN-1:0]   miss_count_o
`endif
);

    localparam int WAYS   = 1 << WAY_LEN;
    localparam int SETS   = 1 << SET_LEN;
    localparam int LINES  = WAYS * SETS;
    localparam int WORDS  = LINES << LINE_LEN;
    localparam int TAG_W  = XLEN - 2 - LINE_LEN - SET_LEN - UNUSED_ADDR_BITS;
    localparam int TAG_LO = 2 + LINE_LEN + SET_LEN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_READ,
        S_DONE,
        S_ABORT
    } state_t;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [WAY_LEN-1:0]  rr_q [SETS];
    logic [WAY_LEN-1:0]  rr_d [SETS];
    logic [WAY_LEN-1:0]  victim_q, victim_d;
    logic [SET_LEN-1:0]  set_q, set_d;
    logic [TAG_W-1:0]    rtag_q, rtag_d;
    logic [LINE_LEN-1:0] idx_q, idx_d;
    logic                flush_pend_q, flush_pend_d;
    logic [ILEN-1:0]     instr_q, instr_d;
    logic                valid_out_q, valid_out_d;
    logic                misaligned_q, misaligned_d;
    logic                fault_q, fault_d;

    // Tag and data storage carry no reset; valid bits qualify them.
    logic [TAG_W-1:0]    tag_mem_q [LINES];
    logic [ILEN-1:0]     data_mem_q [WORDS];
    logic                tag_we;
    logic                data_we;

    logic [LINE_LEN-1:0] lk_word;
    logic [SET_LEN-1:0]  lk_set;
    logic [TAG_W-1:0]    lk_tag;
    logic                lk_hit;
    logic [WAY_LEN-1:0]  lk_way;
    logic                lk_aligned;
    logic                unused_addr;

    // The top address bits are deliberately ignored by the cache.
    assign unused_addr = ^addr_i[XLEN-1:TAG_LO+TAG_W];

    // Combinational lookup: split the fetch address and compare every way of the set.
    always_comb begin
        lk_word    = addr_i[LINE_LEN+1:2];
        lk_set     = addr_i[TAG_LO-1:LINE_LEN+2];
        lk_tag     = addr_i[TAG_LO+TAG_W-1:TAG_LO];
        lk_aligned = (addr_i[1:0] == 2'b00);
        lk_hit     = 1'b0;
        lk_way     = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[{WAY_LEN'(w), lk_set}] &&
                (tag_mem_q[{WAY_LEN'(w), lk_set}] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_LEN'(w);
            end
        end
    end

    // Refill FSM next state, storage write enables and registered outputs.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        rr_d         = rr_q;
        victim_d     = victim_q;
        set_d        = set_q;
        rtag_d       = rtag_q;
        idx_d        = idx_q;
        flush_pend_d = flush_pend_q;
        instr_d      = instr_q;
        valid_out_d  = 1'b0;
        misaligned_d = 1'b0;
        fault_d      = 1'b0;
        tag_we       = 1'b0;
        data_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    // Flush beats a concurrent request: no lookup this cycle.
                    valid_d = '0;
                end else if (req_i) begin
                    if (!lk_aligned) begin
                        misaligned_d = 1'b1;
                    end else if (lk_hit) begin
                        instr_d     = data_mem_q[{lk_way, lk_set, lk_word}];
                        valid_out_d = 1'b1;
                    end else begin
                        state_d  = S_ARB;
                        victim_d = rr_q[lk_set];
                        set_d    = lk_set;
                        rtag_d   = lk_tag;
                    end
                end
            end
            S_ARB: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (ctrl_grant_i) begin
                    state_d = S_READ;
                    idx_d   = '0;
                    // A partially written line must never hit.
                    valid_d[{victim_q, set_q}] = 1'b0;
                end
            end
            S_READ: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (err_i) begin
                    state_d = S_ABORT;
                    fault_d = 1'b1;
                end else if (ack_i) begin
                    data_we = 1'b1;
                    idx_d   = idx_q + LINE_LEN'(1);
                    if (idx_q == {LINE_LEN{1'b1}}) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (flush_pend_q || flush_i) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end else begin
                    tag_we                     = 1'b1;
                    valid_d[{victim_q, set_q}] = 1'b1;
                end
                rr_d[set_q] = rr_q[set_q] + WAY_LEN'(1);
                state_d     = S_IDLE;
            end
            S_ABORT: begin
                // Victim stays invalid and the round-robin pointer is untouched.
                if (flush_pend_q || flush_i) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
            victim_q     <= '0;
            set_q        <= '0;
            rtag_q       <= '0;
            idx_q        <= '0;
            flush_pend_q <= 1'b0;
            instr_q      <= '0;
            valid_out_q  <= 1'b0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            rr_q         <= rr_d;
            victim_q     <= victim_d;
            set_q        <= set_d;
            rtag_q       <= rtag_d;
            idx_q        <= idx_d;
            flush_pend_q <= flush_pend_d;
            instr_q      <= instr_d;
            valid_out_q  <= valid_out_d;
            misaligned_q <= misaligned_d;
            fault_q      <= fault_d;
        end
    end

    // Tag and data RAM writes during refill.
    always_ff @(posedge clk_i) begin
        if (data_we) begin
            data_mem_q[{victim_q, set_q, idx_q}] <= master_dat_i[ILEN-1:0];
        end
        if (tag_we) begin
            tag_mem_q[{victim_q, set_q}] <= rtag_q;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [XLEN-1:0] hit_count_q, hit_count_d;
    logic [XLEN-1:0] miss_count_q, miss_count_d;
    logic            refilled_q, refilled_d;

    // Count hits not caused by the post-refill replay, and every refill start.
    always_comb begin
        refilled_d   = (state_q == S_DONE);
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (valid_out_d && !refilled_q) begin
            hit_count_d = hit_count_q + XLEN'(1);
        end
        if ((state_q == S_IDLE) && (state_d == S_ARB)) begin
            miss_count_d = miss_count_q + XLEN'(1);
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            refilled_q   <= 1'b0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            refilled_q   <= refilled_d;
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
`endif

    assign instr_o      = instr_q;
    assign valid_o      = valid_out_q;
    assign misaligned_o = misaligned_q;
    assign fault_o      = fault_q;
    assign busy_o       = (state_q != S_IDLE);
    assign ctrl_req_o   = (state_q == S_ARB) || (state_q == S_READ);
    assign cyc_o        = (state_q == S_READ);
    assign stb_o        = (state_q == S_READ);
    assign sel_o        = 4'b1111;
    assign adr_o        = {{UNUSED_ADDR_BITS{1'b0}}, rtag_q, set_q, idx_q};

endmodule

// File: tb/tb_rv32im_icache_assoc.sv
// Testbench for rv32im_icache_assoc: directed refill/abort/flush sequences,
// a table of single-cycle lookups and a randomized run against a set/way model.
`timescale 1ns/1ps
module tb_rv32im_icache_assoc;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] instr_o;
    logic        valid_o, busy_o, misaligned_o, fault_o, ctrl_req_o;
    logic        ctrl_grant_i = 1'b0;
    logic [31:0] master_dat_i = '0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic [29:0] adr_o;
    logic        cyc_o, stb_o;
    logic [3:0]  sel_o;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count_o, miss_count_o;
`endif

    rv32im_icache_assoc dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .flush_i      (flush_i),
        .instr_o      (instr_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .misaligned_o (misaligned_o),
        .fault_o      (fault_o),
        .ctrl_req_o   (ctrl_req_o),
        .ctrl_grant_i (ctrl_grant_i),
        .master_dat_i (master_dat_i),
        .ack_i        (ack_i),
        .err_i        (err_i),
        .adr_o        (adr_o),
        .cyc_o        (cyc_o),
        .stb_o        (stb_o),
        .sel_o        (sel_o)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per set, two ways of {valid, tag} and a round-robin pointer.
    logic [15:0] m_tag [4][2];
    bit          m_val [4][2];
    int          m_rr  [4];

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        flush;
        logic        exp_valid;
        logic        exp_mis;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backing-store contents for a byte address (upper byte ignored).
    function automatic logic [31:0] bw(input logic [31:0] a);
        logic [31:0] m;
        m = a & 32'h00FF_FFFC;
        return (m * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int m_lookup(input logic [31:0] a);
        int s;
        s = int'(a[7:6]);
        for (int w = 0; w < 2; w++) begin
            if (m_val[s][w] && (m_tag[s][w] == a[23:8])) return w;
        end
        return -1;
    endfunction

    task automatic m_flush();
        for (int s = 0; s < 4; s++) begin
            m_val[s][0] = 1'b0;
            m_val[s][1] = 1'b0;
        end
    endtask

    task automatic m_reset();
        m_flush();
        for (int s = 0; s < 4; s++) m_rr[s] = 0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_i = 1'b0; flush_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; ctrl_grant_i = 1'b0;
        reset_ni = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_ctrl_req", ctrl_req_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_misaligned", misaligned_o, 0);
`ifdef ICACHE_PERF_EN
        chk("rst_hit_count", hit_count_o, 0);
        chk("rst_miss_count", miss_count_o, 0);
`endif
        @(negedge clk);
        reset_ni = 1'b1;
        m_reset();
    endtask

    // One fetch. Hits expect valid_o next cycle; misses walk the whole refill.
    // err_beat >= 0 aborts on that beat and returns with req_i still held.
    // flush_beat >= 0 pulses flush_i on that beat; the request is then dropped.
    task automatic fetch(input logic [31:0] a, input bit exp_hit, input int gdel,
                         input int err_beat, input int flush_beat, input bit noise);
        logic [31:0] base;
        int s;
        int vw;
        base = (a & 32'h00FF_FFC0) >> 2;
        s = int'(a[7:6]);
        req_i = 1'b1;
        addr_i = a;
        tick();
        if (exp_hit) begin
            chk("hit_valid", valid_o, 1);
            chk("hit_instr", instr_o, bw(a));
            chk("hit_no_cyc", cyc_o, 0);
            chk("hit_no_busy", busy_o, 0);
            req_i = 1'b0;
            return;
        end
        chk("miss_busy", busy_o, 1);
        chk("miss_ctrl_req", ctrl_req_o, 1);
        chk("miss_no_valid", valid_o, 0);
        for (int g = 0; g < gdel; g++) begin
            if (noise) begin
                ack_i = 1'b1; err_i = 1'b1; master_dat_i = 32'hDEAD_BEEF;
            end
            tick();
            chk("arb_no_cyc", cyc_o, 0);
            chk("arb_no_fault", fault_o, 0);
        end
        ack_i = 1'b0; err_i = 1'b0;
        ctrl_grant_i = 1'b1;
        tick();
        chk("read_cyc", cyc_o, 1);
        chk("read_stb", stb_o, 1);
        chk("read_sel", sel_o, 4'hF);
        vw = m_rr[s];
        m_val[s][vw] = 1'b0;
        for (int b = 0; b < 16; b++) begin
            chk("adr_beat", {2'b00, adr_o}, base + 32'(b));
            flush_i = (b == flush_beat);
            if (b == err_beat) begin
                err_i = 1'b1; ack_i = 1'b1; master_dat_i = 32'hFFFF_FFFF;
                tick();
                err_i = 1'b0; ack_i = 1'b0; flush_i = 1'b0; ctrl_grant_i = 1'b0;
                chk("abort_cyc", cyc_o, 0);
                chk("abort_ctrl_req", ctrl_req_o, 0);
                chk("abort_fault", fault_o, 1);
                tick();
                chk("abort_fault_pulse", fault_o, 0);
                chk("abort_idle", busy_o, 0);
                return;
            end
            ack_i = 1'b1;
            master_dat_i = bw((base + 32'(b)) << 2);
            tick();
        end
        ack_i = 1'b0; flush_i = 1'b0; ctrl_grant_i = 1'b0;
        chk("done_cyc", cyc_o, 0);
        chk("done_ctrl_req", ctrl_req_o, 0);
        chk("done_busy", busy_o, 1);
        m_rr[s] = (m_rr[s] + 1) % 2;
        if (flush_beat >= 0) begin
            m_flush();
            req_i = 1'b0;
            tick();
            chk("flush_done_idle", busy_o, 0);
            chk("flush_done_no_valid", valid_o, 0);
            return;
        end
        m_tag[s][vw] = a[23:8];
        m_val[s][vw] = 1'b1;
        tick();
        chk("idle_after_done", busy_o, 0);
        chk("no_valid_before_replay", valid_o, 0);
        tick();
        chk("replay_valid", valid_o, 1);
        chk("replay_instr", instr_o, bw(a));
        chk("replay_not_busy", busy_o, 0);
        req_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h0000_013C, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 32'hAB00_0120, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0102, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 32'h0000_0303, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 32'h0000_0108, 1'b1, 1'b0, 1'b0};

        m_reset();
        do_reset();

        // Basic refill with grant after 2 cycles, then a hit in the same line.
        fetch(32'h100, 1'b0, 2, -1, -1, 1'b0);
        fetch(32'h104, 1'b1, 0, -1, -1, 1'b0);
`ifdef ICACHE_PERF_EN
        chk("perf_miss_count", miss_count_o, 1);
        chk("perf_hit_count", hit_count_o, 1);
`endif

        // Single-cycle lookups: hits, ignored upper bits, misaligned, idle, flush+req.
        for (int i = 0; i < 6; i++) begin
            req_i = tbl[i].req; addr_i = tbl[i].addr; flush_i = tbl[i].flush;
            tick();
            chk("tbl_valid", valid_o, tbl[i].exp_valid);
            chk("tbl_misaligned", misaligned_o, tbl[i].exp_mis);
            chk("tbl_not_busy", busy_o, 0);
            if (tbl[i].exp_valid) chk("tbl_instr", instr_o, bw(tbl[i].addr));
            if (tbl[i].flush) m_flush();
            req_i = 1'b0; flush_i = 1'b0;
        end
        fetch(32'h100, 1'b0, 0, -1, -1, 1'b0);

        // Three lines into one 2-way set: round-robin eviction.
        do_reset();
        fetch(32'h000, 1'b0, 1, -1, -1, 1'b0);
        fetch(32'h100, 1'b0, 0, -1, -1, 1'b0);
        fetch(32'h200, 1'b0, 3, -1, -1, 1'b0);
        fetch(32'h100, 1'b1, 0, -1, -1, 1'b0);
        fetch(32'h000, 1'b0, 0, -1, -1, 1'b0);
        fetch(32'h200, 1'b1, 0, -1, -1, 1'b0);

        // Bus error on the 5th beat, then the held request retries.
        do_reset();
        fetch(32'h000, 1'b0, 2, 4, -1, 1'b1);
        fetch(32'h000, 1'b0, 0, -1, -1, 1'b0);
        fetch(32'h03C, 1'b1, 0, -1, -1, 1'b0);

        // Flush during a refill: the refilled line stays invalid.
        fetch(32'h100, 1'b0, 0, -1, -1, 1'b0);
        fetch(32'h300, 1'b0, 1, -1, 7, 1'b0);
        fetch(32'h300, 1'b0, 0, -1, -1, 1'b0);
        fetch(32'h100, 1'b0, 0, -1, -1, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        for (int it = 0; it < 60; it++) begin
            int r;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            a = ($urandom & 32'hFF00_0000) | ($urandom_range(0, 3) << 8) |
                ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            if (r == 0) begin
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
                chk("rnd_flush_not_busy", busy_o, 0);
                chk("rnd_flush_no_valid", valid_o, 0);
                m_flush();
            end else if (r == 1) begin
                req_i = 1'b1; addr_i = a | 32'($urandom_range(1, 3));
                tick();
                req_i = 1'b0;
                chk("rnd_misaligned", misaligned_o, 1);
                chk("rnd_mis_no_valid", valid_o, 0);
                chk("rnd_mis_not_busy", busy_o, 0);
            end else if (m_lookup(a) >= 0) begin
                fetch(a, 1'b1, 0, -1, -1, 1'b0);
            end else begin
                int eb;
                int gd;
                eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
                gd = int'($urandom_range(0, 3));
                fetch(a, 1'b0, gd, eb, -1, 1'($urandom_range(0, 1)));
                if (eb >= 0) fetch(a, 1'b0, gd, -1, -1, 1'b0);
            end
        end

        // Reset asserted in the middle of a refill.
        req_i = 1'b1; addr_i = 32'h0000_0540;
        tick();
        ctrl_grant_i = 1'b1;
        tick();
        for (int b = 0; b < 3; b++) begin
            ack_i = 1'b1; master_dat_i = bw(32'h540 + 32'(b * 4));
            tick();
        end
        chk("mid_cyc_before_reset", cyc_o, 1);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("mid_reset_cyc", cyc_o, 0);
        chk("mid_reset_stb", stb_o, 0);
        chk("mid_reset_ctrl_req", ctrl_req_o, 0);
        chk("mid_reset_busy", busy_o, 0);
`ifdef ICACHE_PERF_EN
        chk("mid_reset_hit_count", hit_count_o, 0);
        chk("mid_reset_miss_count", miss_count_o, 0);
`endif
        req_i = 1'b0; ack_i = 1'b0; ctrl_grant_i = 1'b0;
        tick();
        reset_ni = 1'b1;
        m_reset();
        fetch(32'h540, 1'b0, 0, -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
